regfile_wb_arbiter: RTL and testbench

Write-back arbiter and pending-write scoreboard for the 32 x 32-bit register file. It shares the register file's single write port among `NUM_REQ` write-back producers, such as the ALU, load unit and multiply/divide unit, and grants at most one write per cycle. It also tracks which registers have an in-flight producer, so the issue stage can detect RAW hazards on its two read operands. It sits between the execution units and the register file's `RegWrite`/`WriteReg`/`WriteData` inputs.

---
 rtl/regfile_wb_arbiter_if.sv | 30 +++
 rtl/regfile_wb_arbiter.sv | 108 ++++++++++
 tb/tb_regfile_wb_arbiter.sv | 228 ++++++++++++++++++++++
 3 files changed

// File: rtl/regfile_wb_arbiter_if.sv
// Bus bundle between the write-back producers / issue stage and the register-file write-back arbiter.
interface regfile_wb_arbiter_if #(
    parameter int NUM_REQ = 3,
    parameter int ADDR_W  = 5,
    parameter int DATA_W  = 32
);
    logic [NUM_REQ-1:0]        ReqValid;
    logic [NUM_REQ*ADDR_W-1:0] ReqReg;
    logic [NUM_REQ*DATA_W-1:0] ReqData;
    logic [NUM_REQ-1:0]        ReqReady;
    logic                      RegWrite;
    logic [ADDR_W-1:0]         WriteReg;
    logic [DATA_W-1:0]         WriteData;
    logic                      ClaimValid;
    logic [ADDR_W-1:0]         ClaimReg;
    logic [ADDR_W-1:0]         CheckReg1;
    logic [ADDR_W-1:0]         CheckReg2;
    logic                      Busy1;
    logic                      Busy2;

    modport master (
        output ReqValid, ReqReg, ReqData, ClaimValid, ClaimReg, CheckReg1, CheckReg2,
        input  ReqReady, RegWrite, WriteReg, WriteData, Busy1, Busy2
    );

    modport slave (
        input  ReqValid, ReqReg, ReqData, ClaimValid, ClaimReg, CheckReg1, CheckReg2,
        output ReqReady, RegWrite, WriteReg, WriteData, Busy1, Busy2
    );
endinterface

// File: rtl/regfile_wb_arbiter.sv
// Register-file write-port arbiter with pending-write scoreboard for RAW hazard detection.
// Define REGFILE_WB_RR_EN for round-robin grants; otherwise the lowest requesting index wins.
module regfile_wb_arbiter #(
    parameter int NUM_REQ = 3,
    parameter int ADDR_W  = 5,
    parameter int DATA_W  = 32
) (
    input logic clock,
    input logic reset_n,
    regfile_wb_arbiter_if.slave bus
);
    localparam int IDX_W    = (NUM_REQ > 1) ? $clog2(NUM_REQ) : 1;
    localparam int NUM_REGS = 1 << ADDR_W;

    logic [NUM_REQ-1:0]  grant;
    logic [IDX_W-1:0]    grantIdx;
    logic                grantAny;
    logic [ADDR_W-1:0]   selReg;
    logic [DATA_W-1:0]   selData;
    logic                regWriteQ;
    logic [ADDR_W-1:0]   writeRegQ;
    logic [DATA_W-1:0]   writeDataQ;
    logic [NUM_REGS-1:0] scoreboard;
    logic [NUM_REGS-1:0] scoreboardNext;

`ifdef REGFILE_WB_RR_EN
    logic [IDX_W-1:0] rrPtr;

    function automatic logic [IDX_W-1:0] rotIdx(input logic [IDX_W-1:0] base, input int k);
        int s;
        s = int'(base) + k;
        return IDX_W'(s % NUM_REQ);
    endfunction

    // Search starts at rrPtr, which points just past the last winner.
    always_comb begin
        grantAny = 1'b0;
        grantIdx = '0;
        for (int k = 0; k < NUM_REQ; k++) begin
            if (!grantAny && bus.ReqValid[rotIdx(rrPtr, k)]) begin
                grantAny = 1'b1;
                grantIdx = rotIdx(rrPtr, k);
            end
        end
        if (!reset_n) grantAny = 1'b0;
    end

    always_ff @(posedge clock) begin
        if (!reset_n) begin
            rrPtr <= '0;
        end else if (grantAny) begin
            rrPtr <= (grantIdx == IDX_W'(NUM_REQ - 1)) ? '0 : grantIdx + 1'b1;
        end
    end
`else
    always_comb begin
        grantAny = 1'b0;
        grantIdx = '0;
        for (int i = 0; i < NUM_REQ; i++) begin
            if (!grantAny && bus.ReqValid[i]) begin
                grantAny = 1'b1;
                grantIdx = IDX_W'(i);
            end
        end
        if (!reset_n) grantAny = 1'b0;
    end
`endif

    always_comb begin
        grant = '0;
        if (grantAny) grant[grantIdx] = 1'b1;
    end

    assign selReg  = bus.ReqReg[int'(grantIdx) * ADDR_W +: ADDR_W];
    assign selData = bus.ReqData[int'(grantIdx) * DATA_W +: DATA_W];

    // A newer claim overrides the clear from a retiring write to the same register.
    always_comb begin
        scoreboardNext = scoreboard;
        if (regWriteQ) scoreboardNext[writeRegQ] = 1'b0;
        if (bus.ClaimValid) scoreboardNext[bus.ClaimReg] = 1'b1;
        scoreboardNext[0] = 1'b0;
    end

    // Writes to R0 are consumed but never reach the register file.
    always_ff @(posedge clock) begin
        if (!reset_n) begin
            regWriteQ  <= 1'b0;
            writeRegQ  <= '0;
            writeDataQ <= '0;
            scoreboard <= '0;
        end else begin
            regWriteQ  <= grantAny && (selReg != '0);
            if (grantAny) begin
                writeRegQ  <= selReg;
                writeDataQ <= selData;
            end
            scoreboard <= scoreboardNext;
        end
    end

    assign bus.ReqReady  = grant;
    assign bus.RegWrite  = regWriteQ;
    assign bus.WriteReg  = writeRegQ;
    assign bus.WriteData = writeDataQ;
    assign bus.Busy1     = scoreboard[bus.CheckReg1];
    assign bus.Busy2     = scoreboard[bus.CheckReg2];
endmodule

// File: tb/tb_regfile_wb_arbiter.sv
// Scoreboard bench for regfile_wb_arbiter: directed scenarios plus randomized traffic against a reference model.
module tb_regfile_wb_arbiter;
    localparam int N  = 3;
    localparam int AW = 5;
    localparam int DW = 32;

    logic clock = 1'b0;
    logic reset_n = 1'b0;
    always #5 clock = ~clock;

    regfile_wb_arbiter_if #(.NUM_REQ(N), .ADDR_W(AW), .DATA_W(DW)) bus ();
    regfile_wb_arbiter #(.NUM_REQ(N), .ADDR_W(AW), .DATA_W(DW)) dut (
        .clock(clock), .reset_n(reset_n), .bus(bus)
    );

    typedef struct {
        logic [AW-1:0] r;
        logic [DW-1:0] d;
    } wr_t;

    int checks = 0;
    int errors = 0;
    wr_t expQ[$];
    wr_t monE;
    bit sbM[32];
    int ptrM = 0;
    bit lastWrV = 0;
    logic [AW-1:0] lastWrR = '0;
    bit monOn = 0;

    task automatic check(input string name, input logic [63:0] act, input logic [63:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s: got %0h expected %0h at %0t", name, act, exp, $time);
        end
    endtask

    // Monitor: every cycle the registered write port must match what the model queued.
    initial begin
        forever begin
            @(posedge clock);
            #1;
            if (monOn) begin
                if (expQ.size() > 0) begin
                    monE = expQ.pop_front();
                    check("RegWrite", 64'(bus.RegWrite), 64'd1);
                    check("WriteReg", 64'(bus.WriteReg), 64'(monE.r));
                    check("WriteData", 64'(bus.WriteData), 64'(monE.d));
                end else begin
                    check("RegWrite idle", 64'(bus.RegWrite), 64'd0);
                end
            end
        end
    end

    // One clock cycle: drive at negedge, check combinational outputs, advance the model over the edge.
    task automatic step(input bit rstn, input logic [N-1:0] vld, input logic [N*AW-1:0] regs,
                        input logic [N*DW-1:0] data, input bit cv, input logic [AW-1:0] cr,
                        input logic [AW-1:0] c1, input logic [AW-1:0] c2,
                        output int gnt, output logic [N-1:0] rdy, output logic b1, output logic b2);
        logic [N-1:0] expRdy;
        logic [AW-1:0] r;
        @(negedge clock);
        reset_n = rstn;
        bus.ReqValid = vld;
        bus.ReqReg = regs;
        bus.ReqData = data;
        bus.ClaimValid = cv;
        bus.ClaimReg = cr;
        bus.CheckReg1 = c1;
        bus.CheckReg2 = c2;
        #1;
        gnt = -1;
        if (rstn) begin
`ifdef REGFILE_WB_RR_EN
            for (int k = 0; k < N; k++) begin
                int i;
                i = (ptrM + k) % N;
                if (gnt < 0 && vld[i]) gnt = i;
            end
`else
            for (int i = 0; i < N; i++) if (gnt < 0 && vld[i]) gnt = i;
`endif
        end
        expRdy = '0;
        if (gnt >= 0) expRdy[gnt] = 1'b1;
        rdy = bus.ReqReady;
        b1 = bus.Busy1;
        b2 = bus.Busy2;
        check("ReqReady", 64'(rdy), 64'(expRdy));
        check("Busy1", 64'(b1), 64'(sbM[c1]));
        check("Busy2", 64'(b2), 64'(sbM[c2]));
        if (!rstn) begin
            sbM = '{default: 1'b0};
            ptrM = 0;
            lastWrV = 0;
        end else begin
            if (lastWrV) sbM[lastWrR] = 1'b0;
            if (cv && cr != 0) sbM[cr] = 1'b1;
            lastWrV = 0;
            if (gnt >= 0) begin
                ptrM = (gnt + 1) % N;
                r = regs[gnt*AW +: AW];
                if (r != 0) begin
                    expQ.push_back('{r: r, d: data[gnt*DW +: DW]});
                    lastWrV = 1;
                    lastWrR = r;
                end
            end
        end
    endtask

    initial begin
        int gnt;
        logic [N-1:0] rdy;
        logic b1, b2;
        logic [N-1:0] expOne;
        logic [N-1:0] pv;
        logic [N*AW-1:0] pr;
        logic [N*DW-1:0] pd;
        bit rb;

        sbM = '{default: 1'b0};
        bus.ReqValid = '0;
        bus.ReqReg = '0;
        bus.ReqData = '0;
        bus.ClaimValid = 1'b0;
        bus.ClaimReg = '0;
        bus.CheckReg1 = '0;
        bus.CheckReg2 = '0;
        reset_n = 1'b0;
        @(posedge clock);
        #1;
        check("reset RegWrite", 64'(bus.RegWrite), 64'd0);
        check("reset WriteReg", 64'(bus.WriteReg), 64'd0);
        check("reset WriteData", 64'(bus.WriteData), 64'd0);
        check("reset ReqReady", 64'(bus.ReqReady), 64'd0);
        monOn = 1;
        step(0, '0, '0, '0, 0, '0, '0, '0, gnt, rdy, b1, b2);

        // Single write from requester 1 to R5
        step(1, 3'b010, {5'd0, 5'd5, 5'd0}, {32'd0, 32'hDEADBEEF, 32'd0}, 0, '0, 5'd5, '0, gnt, rdy, b1, b2);
        check("single grant", 64'(rdy), 64'(3'b010));
        step(1, '0, '0, '0, 0, '0, '0, '0, gnt, rdy, b1, b2);
        step(1, '0, '0, '0, 0, '0, '0, '0, gnt, rdy, b1, b2);

        // Fairness with all requesters busy, starting from reset
        step(0, '0, '0, '0, 0, '0, '0, '0, gnt, rdy, b1, b2);
        for (int k = 0; k < 6; k++) begin
            step(1, 3'b111, {5'd3, 5'd2, 5'd1}, {32'hC, 32'hB, 32'hA}, 0, '0, '0, '0, gnt, rdy, b1, b2);
`ifdef REGFILE_WB_RR_EN
            expOne = N'(1 << (k % 3));
`else
            expOne = N'(1);
`endif
            check("fairness grant", 64'(rdy), 64'(expOne));
        end
        step(1, '0, '0, '0, 0, '0, '0, '0, gnt, rdy, b1, b2);

        // Scoreboard lifecycle for R7
        step(1, '0, '0, '0, 1, 5'd7, 5'd7, '0, gnt, rdy, b1, b2);
        step(1, '0, '0, '0, 0, '0, 5'd7, '0, gnt, rdy, b1, b2);
        check("R7 busy c1", 64'(b1), 64'd1);
        step(1, '0, '0, '0, 0, '0, 5'd7, '0, gnt, rdy, b1, b2);
        check("R7 busy c2", 64'(b1), 64'd1);
        step(1, 3'b100, {5'd7, 10'd0}, {32'h77, 64'd0}, 0, '0, 5'd7, '0, gnt, rdy, b1, b2);
        check("R7 busy c3", 64'(b1), 64'd1);
        step(1, '0, '0, '0, 0, '0, 5'd7, '0, gnt, rdy, b1, b2);
        check("R7 busy c4", 64'(b1), 64'd1);
        check("R7 RegWrite c4", 64'(bus.RegWrite), 64'd1);
        step(1, '0, '0, '0, 0, '0, 5'd7, '0, gnt, rdy, b1, b2);
        check("R7 free c5", 64'(b1), 64'd0);

        // R0 write and R0 claim
        step(1, 3'b001, {10'd0, 5'd0}, {64'd0, 32'h1234}, 1, 5'd0, '0, 5'd0, gnt, rdy, b1, b2);
        check("R0 grant", 64'(rdy[0]), 64'd1);
        step(1, '0, '0, '0, 0, '0, '0, 5'd0, gnt, rdy, b1, b2);
        check("R0 busy", 64'(b2), 64'd0);
        check("R0 RegWrite", 64'(bus.RegWrite), 64'd0);

        // Claim and clear of R9 at the same edge
        step(1, '0, '0, '0, 1, 5'd9, 5'd9, '0, gnt, rdy, b1, b2);
        step(1, 3'b001, {10'd0, 5'd9}, {64'd0, 32'h99}, 0, '0, 5'd9, '0, gnt, rdy, b1, b2);
        step(1, '0, '0, '0, 1, 5'd9, 5'd9, '0, gnt, rdy, b1, b2);
        check("R9 clear edge RegWrite", 64'(bus.RegWrite), 64'd1);
        step(1, '0, '0, '0, 0, '0, 5'd9, '0, gnt, rdy, b1, b2);
        check("R9 set wins", 64'(b1), 64'd1);
        step(1, '0, '0, '0, 0, '0, 5'd9, '0, gnt, rdy, b1, b2);
        check("R9 still busy", 64'(b1), 64'd1);

        // Reset in the middle of traffic
        step(1, '0, '0, '0, 1, 5'd3, '0, '0, gnt, rdy, b1, b2);
        step(1, 3'b001, {10'd0, 5'd5}, {64'd0, 32'h55}, 1, 5'd4, 5'd3, 5'd4, gnt, rdy, b1, b2);
        step(0, 3'b111, {5'd1, 5'd2, 5'd3}, '0, 0, '0, 5'd3, 5'd4, gnt, rdy, b1, b2);
        check("reset busy R3 before edge", 64'(b1), 64'd1);
        check("reset forces ReqReady", 64'(rdy), 64'd0);
        step(1, 3'b110, {5'd11, 5'd10, 5'd0}, {32'hB1, 32'hA1, 32'd0}, 0, '0, 5'd3, 5'd4, gnt, rdy, b1, b2);
        check("post-reset busy R3", 64'(b1), 64'd0);
        check("post-reset busy R4", 64'(b2), 64'd0);
        check("post-reset grant", 64'(rdy), 64'(3'b010));
        step(1, '0, '0, '0, 0, '0, '0, '0, gnt, rdy, b1, b2);

        // Randomized traffic; pending requesters hold register and data until granted
        pv = '0;
        pr = '0;
        pd = '0;
        for (int n = 0; n < 2000; n++) begin
            for (int i = 0; i < N; i++) begin
                if (!pv[i] && $urandom_range(0, 2) == 0) begin
                    pv[i] = 1'b1;
                    pr[i*AW +: AW] = AW'($urandom_range(0, 7));
                    pd[i*DW +: DW] = $urandom;
                end
            end
            rb = ($urandom_range(0, 199) != 0);
            step(rb, pv, pr, pd, $urandom_range(0, 2) == 0, AW'($urandom_range(0, 7)),
                 AW'($urandom_range(0, 7)), AW'($urandom_range(0, 31)), gnt, rdy, b1, b2);
            if (gnt >= 0) pv[gnt] = 1'b0;
        end

        step(1, '0, '0, '0, 0, '0, '0, '0, gnt, rdy, b1, b2);
        step(1, '0, '0, '0, 0, '0, '0, '0, gnt, rdy, b1, b2);
        check("queue drained", 64'(expQ.size()), 64'd0);
        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end
endmodule
